ram_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one single-port synchronous RAM (ce/we/addr/datai, registered datao)

---
 rtl/ram_arb_pkg.sv | 16 +
 rtl/ram_arb_rr.sv | 29 ++
 rtl/ram_arbiter.sv | 164 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the single-port RAM round-robin arbiter.
package ram_arb_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  function automatic int rr_next(input int ptr, input int nreq);
    return (ptr + 1) % nreq;
  endfunction

endpackage

// File: rtl/ram_arb_rr.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module ram_arb_rr #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [PW-1:0]   win_idx,
  output logic            win_any
);

  always_comb begin
    int j;
    win_oh  = '0;
    win_idx = '0;
    win_any = 1'b0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!win_any && req[j]) begin
        win_any   = 1'b1;
        win_oh[j] = 1'b1;
        win_idx   = PW'(j);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin sequencer sharing one single-port registered-output RAM among NREQ clients.
// Optional per-requester saturating grant counters when RAM_ARB_CNT_EN is defined.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int AW    = 4,
  parameter int DW    = 4,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       we,
  input  logic [NREQ*AW-1:0]    addr,
  input  logic [NREQ*DW-1:0]    wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       err,
  output logic [NREQ-1:0]       rvalid,
  output logic [DW-1:0]         rdata,
  output logic [NREQ*CNT_W-1:0] gnt_cnt,
  output logic                  ce_mem,
  output logic                  we_mem,
  output logic [AW-1:0]         addr_mem,
  output logic [DW-1:0]         datai_mem,
  input  logic [DW-1:0]         datao_mem
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     wid_q, wid_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   err_q, err_d;
  logic [NREQ-1:0]   rvalid_q, rvalid_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              ce_q, ce_d;
  logic              wem_q, wem_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     datai_q, datai_d;

  logic [NREQ-1:0]   win_oh;
  logic [PW-1:0]     win_idx;
  logic              win_any;
  logic [AW-1:0]     win_addr;
  logic [DW-1:0]     win_wdata;
  logic              win_oor;

  ram_arb_rr #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req     (req),
    .ptr     (ptr_q),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_any (win_any)
  );

  assign win_addr  = addr[win_idx*AW +: AW];
  assign win_wdata = wdata[win_idx*DW +: DW];
  assign win_oor   = ({1'b0, win_addr} >= (AW+1)'(DEPTH));

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    wid_d    = wid_q;
    gnt_d    = '0;
    err_d    = '0;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    ce_d     = 1'b0;
    wem_d    = wem_q;
    addr_d   = addr_q;
    datai_d  = datai_q;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          gnt_d = win_oh;
          wid_d = win_idx;
          ptr_d = PW'(rr_next(int'(win_idx), NREQ));
          if (win_oor) begin
            // Out-of-range grant: acknowledged with err, RAM never touched.
            err_d = win_oh;
          end else begin
            ce_d    = 1'b1;
            wem_d   = we[win_idx];
            addr_d  = win_addr;
            datai_d = win_wdata;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = wem_q ? IDLE : RD_WAIT;
      end
      RD_WAIT: begin
        rdata_d         = datao_mem;
        rvalid_d[wid_q] = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      wid_q    <= '0;
      gnt_q    <= '0;
      err_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      ce_q     <= 1'b0;
      wem_q    <= 1'b0;
      addr_q   <= '0;
      datai_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      wid_q    <= wid_d;
      gnt_q    <= gnt_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      ce_q     <= ce_d;
      wem_q    <= wem_d;
      addr_q   <= addr_d;
      datai_q  <= datai_d;
    end
  end

`ifdef RAM_ARB_CNT_EN
  logic [NREQ*CNT_W-1:0] cnt_q, cnt_d;

  // Counted against gnt_d so the count already includes a grant while it is visible.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_d[i] && (cnt_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
        cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign gnt_cnt = cnt_q;
`else
  assign gnt_cnt = '0;
`endif

  assign gnt       = gnt_q;
  assign err       = err_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign ce_mem    = ce_q;
  assign we_mem    = wem_q;
  assign addr_mem  = addr_q;
  assign datai_mem = datai_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural registered-output RAM attached to the *_mem ports.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  we = '0;
  logic [7:0]  addr = '0;
  logic [7:0]  wdata = '0;
  logic [1:0]  gnt, err, rvalid;
  logic [3:0]  rdata;
  logic [15:0] gnt_cnt;
  logic        ce_mem, we_mem;
  logic [3:0]  addr_mem, datai_mem;
  logic [3:0]  datao_mem = '0;
  logic [3:0]  mem [0:15];

  int vectors = 0;
  int miscompares = 0;
  int ngrants;

  ram_arbiter #(.NREQ(2), .AW(4), .DW(4), .DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .err(err), .rvalid(rvalid), .rdata(rdata), .gnt_cnt(gnt_cnt),
    .ce_mem(ce_mem), .we_mem(we_mem), .addr_mem(addr_mem),
    .datai_mem(datai_mem), .datao_mem(datao_mem)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ce_mem) begin
      if (we_mem) mem[addr_mem] <= datai_mem;
      else        datao_mem <= mem[addr_mem];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic w, input logic [3:0] a, input logic [3:0] d);
    req[i]          = 1'b1;
    we[i]           = w;
    addr[i*4 +: 4]  = a;
    wdata[i*4 +: 4] = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},    32'(gnt), 0);
    chk({tag, "_err"},    32'(err), 0);
    chk({tag, "_rvalid"}, 32'(rvalid), 0);
    chk({tag, "_rdata"},  32'(rdata), 0);
    chk({tag, "_ce"},     32'(ce_mem), 0);
    chk({tag, "_we"},     32'(we_mem), 0);
    chk({tag, "_addr"},   32'(addr_mem), 0);
    chk({tag, "_datai"},  32'(datai_mem), 0);
    chk({tag, "_cnt"},    32'(gnt_cnt), 0);
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    tick();
    rstn = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset state
    #1;
    chk_all_zero("rst");
    tick();
    rstn = 1'b0;

    // Reset while a write is being issued: ce_mem must drop without a clock edge
    set_req(0, 1'b1, 4'd0, 4'hF);
    tick();
    chk("rst_mid_ce_pre", 32'(ce_mem), 1);
    req = '0;
    #2 rstn = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    tick();
    rstn = 1'b0;

    // Write then read addr 2
    set_req(0, 1'b1, 4'd2, 4'hA);
    tick();
    chk("wr_gnt", 32'(gnt), 2'b01);
    chk("wr_ce", 32'(ce_mem), 1);
    chk("wr_we", 32'(we_mem), 1);
    chk("wr_addr", 32'(addr_mem), 2);
    chk("wr_datai", 32'(datai_mem), 4'hA);
    chk("wr_err", 32'(err), 0);
    req = '0;
    tick();
    chk("wr_ce_drop", 32'(ce_mem), 0);
    chk("wr_gnt_drop", 32'(gnt), 0);
    set_req(0, 1'b0, 4'd2, 4'h0);
    tick();
    chk("rd_gnt", 32'(gnt), 2'b01);
    chk("rd_ce", 32'(ce_mem), 1);
    chk("rd_we", 32'(we_mem), 0);
    req = '0;
    tick();
    chk("rd_rvalid_early", 32'(rvalid), 0);
    tick();
    chk("rd_rvalid", 32'(rvalid), 2'b01);
    chk("rd_rdata", 32'(rdata), 4'hA);
    tick();
    chk("rd_rvalid_pulse", 32'(rvalid), 0);
    chk("rd_rdata_hold", 32'(rdata), 4'hA);

    // Pointer now favours req1: write addr 1 = 5 through req1
    set_req(1, 1'b1, 4'd1, 4'h5);
    tick();
    chk("wr1_gnt", 32'(gnt), 2'b10);
    req = '0;
    tick();

    // Contention from reset: both reads held continuously
    do_reset();
    set_req(0, 1'b0, 4'd2, 4'h0);
    set_req(1, 1'b0, 4'd1, 4'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("cont_gnt%0d", k), 32'(gnt), (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      tick();
      chk($sformatf("cont_rv%0d", k), 32'(rvalid), (k % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("cont_rd%0d", k), 32'(rdata), (k % 2 == 0) ? 4'hA : 4'h5);
    end
    req = '0;

    // Out-of-range: move pointer to req1 by granting req0 a write (addr 3 = 7)
    set_req(0, 1'b1, 4'd3, 4'h7);
    tick();
    chk("oor_pre_gnt", 32'(gnt), 2'b01);
    req = '0;
    tick();
    set_req(0, 1'b0, 4'd3, 4'h0);
    set_req(1, 1'b0, 4'd5, 4'h0);
    tick();
    chk("oor_gnt", 32'(gnt), 2'b10);
    chk("oor_err", 32'(err), 2'b10);
    chk("oor_ce", 32'(ce_mem), 0);
    req[1] = 1'b0;
    tick();
    chk("oor_next_gnt", 32'(gnt), 2'b01);
    chk("oor_next_err", 32'(err), 0);
    chk("oor_next_ce", 32'(ce_mem), 1);
    req = '0;
    tick();
    chk("oor_no_rvalid", 32'(rvalid), 0);
    tick();
    chk("oor_rv", 32'(rvalid), 2'b01);
    chk("oor_rd", 32'(rdata), 4'h7);

    // Reset during RD_WAIT drops the read; pointer returns to req0
    set_req(0, 1'b0, 4'd2, 4'h0);
    tick();
    chk("rdw_gnt", 32'(gnt), 2'b01);
    req = '0;
    tick();
    rstn = 1'b1;
    #1;
    chk_all_zero("rdw_rst");
    tick();
    chk("rdw_no_rvalid", 32'(rvalid), 0);
    rstn = 1'b0;
    set_req(0, 1'b0, 4'd2, 4'h0);
    set_req(1, 1'b0, 4'd1, 4'h0);
    tick();
    chk("rdw_first", 32'(gnt), 2'b01);
    req[0] = 1'b0;
    tick();
    tick();
    chk("rdw_rv0", 32'(rvalid), 2'b01);
    chk("rdw_rd0", 32'(rdata), 4'hA);
    tick();
    chk("rdw_second", 32'(gnt), 2'b10);
    req = '0;
    tick();
    tick();
    chk("rdw_rv1", 32'(rvalid), 2'b10);
    chk("rdw_rd1", 32'(rdata), 4'h5);

    // 300 back-to-back error grants to req1
    do_reset();
    ngrants = 0;
    set_req(1, 1'b0, 4'd9, 4'h0);
    for (int k = 0; k < 300; k++) begin
      tick();
      if (gnt == 2'b10 && err == 2'b10) ngrants++;
    end
    req = '0;
    chk("cnt_grants", 32'(ngrants), 300);
`ifdef RAM_ARB_CNT_EN
    chk("cnt_req1", 32'(gnt_cnt[15:8]), 255);
    chk("cnt_req0", 32'(gnt_cnt[7:0]), 0);
`else
    chk("cnt_off", 32'(gnt_cnt), 0);
`endif
    tick();
    chk("cnt_idle_gnt", 32'(gnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
